// File: rtl/ball_pkg.sv
// Shared keycodes and autopilot state encoding for the ball mover and its autopilot.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ball_pkg;

   // Arrow keycodes as seen by the ball mover
   localparam logic [7:0] KEY_NONE  = 8'd0;
   localparam logic [7:0] KEY_RIGHT = 8'd79;
   localparam logic [7:0] KEY_LEFT  = 8'd80;
   localparam logic [7:0] KEY_DOWN  = 8'd81;
   localparam logic [7:0] KEY_UP    = 8'd82;

   typedef enum logic [2:0] {
      AP_IDLE,
      AP_REACT,
      AP_CHASE_X,
      AP_CHASE_Y,
      AP_ARRIVED
   } ap_state_t;

   // Arrow key for one axis from the sign of its error; zero error gives no key
   function automatic logic [7:0] axis_key(input logic pos, input logic neg,
                                           input logic [7:0] key_pos,
                                           input logic [7:0] key_neg);
      if (pos)
         return key_pos;
      else if (neg)
         return key_neg;
      else
         return KEY_NONE;
   endfunction

endpackage

// File: rtl/ball_autopilot_axis_err.sv
// Per-axis position error: sign flags, magnitude and dead-zone hit.
// Latency: purely combinational.
// Backpressure: not applicable.
module axis_err #(
   parameter int DEAD_ZONE = 2
) (
   input  logic [9:0] target,
   input  logic [9:0] own,
   output logic       pos,
   output logic       neg,
   output logic [9:0] mag,
   output logic       in_dz
);

   localparam logic [9:0] DZ = 10'(DEAD_ZONE);

   logic signed [10:0] err;
   logic signed [10:0] err_neg;

   // Zero-extend both operands so the 11-bit difference never overflows
   assign err     = $signed({1'b0, target}) - $signed({1'b0, own});
   assign err_neg = -err;

   assign pos   = ~err[10] & (err != 11'sd0);
   assign neg   = err[10];
   assign mag   = err[10] ? err_neg[9:0] : err[9:0];
   assign in_dz = (mag <= DZ);

endmodule

// File: rtl/ball_autopilot.sv
// Arrow-key autopilot steering the ball to a target, axis by axis, or manual keycode pass-through.
// Latency: one frame for pass-through; REACT_FRAMES+1 frames from enable to the first arrow key.
// Backpressure: none; one decision per frame_clk, the mover consumes every keycode.
module ball_autopilot
   import ball_pkg::*;
#(
   parameter int DEAD_ZONE    = 2,
   parameter int REACT_FRAMES = 8,
   parameter int AXIS_HOLD    = 16
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       enable,
   input  logic [7:0] manual_keycode,
   input  logic [9:0] own_x,
   input  logic [9:0] own_y,
   input  logic [9:0] target_x,
   input  logic [9:0] target_y,
   output logic [7:0] keycode,
   output logic       busy,
   output logic       arrived
);

   localparam logic [7:0] REACT_LAST = 8'(REACT_FRAMES - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(AXIS_HOLD - 1);

   ap_state_t  state_q;
   logic [7:0] react_cnt_q;
   logic [7:0] axis_cnt_q;
   logic [7:0] keycode_q;
   logic       busy_q;
   logic       arrived_q;

   logic       pos_x, neg_x, dz_x;
   logic       pos_y, neg_y, dz_y;
   logic [9:0] mag_x, mag_y;
   logic [7:0] key_x, key_y;

   axis_err #(.DEAD_ZONE(DEAD_ZONE)) u_err_x (
      .target (target_x),
      .own    (own_x),
      .pos    (pos_x),
      .neg    (neg_x),
      .mag    (mag_x),
      .in_dz  (dz_x)
   );

   axis_err #(.DEAD_ZONE(DEAD_ZONE)) u_err_y (
      .target (target_y),
      .own    (own_y),
      .pos    (pos_y),
      .neg    (neg_y),
      .mag    (mag_y),
      .in_dz  (dz_y)
   );

   // Y grows downward on screen, so a positive Y error means DOWN
   assign key_x = axis_key(pos_x, neg_x, KEY_RIGHT, KEY_LEFT);
   assign key_y = axis_key(pos_y, neg_y, KEY_DOWN, KEY_UP);

   // Autopilot FSM; every output is registered with the state being entered
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= AP_IDLE;
         react_cnt_q <= 8'd0;
         axis_cnt_q  <= 8'd0;
         keycode_q   <= KEY_NONE;
         busy_q      <= 1'b0;
         arrived_q   <= 1'b0;
      end else if (!enable) begin
         // Dropping enable beats every other transition, including arrival
         state_q     <= AP_IDLE;
         react_cnt_q <= 8'd0;
         axis_cnt_q  <= 8'd0;
         keycode_q   <= manual_keycode;
         busy_q      <= 1'b0;
         arrived_q   <= 1'b0;
      end else begin
         case (state_q)
            AP_IDLE: begin
               state_q     <= AP_REACT;
               react_cnt_q <= 8'd0;
               keycode_q   <= KEY_NONE;
               busy_q      <= 1'b1;
               arrived_q   <= 1'b0;
            end

            AP_REACT: begin
               react_cnt_q <= react_cnt_q + 8'd1;
               keycode_q   <= KEY_NONE;
               if (react_cnt_q == REACT_LAST) begin
                  axis_cnt_q <= 8'd0;
                  if (dz_x && dz_y) begin
                     state_q   <= AP_ARRIVED;
                     busy_q    <= 1'b0;
                     arrived_q <= 1'b1;
                  end else if (mag_x >= mag_y) begin
                     // Larger error first; a tie goes to X
                     state_q   <= AP_CHASE_X;
                     keycode_q <= key_x;
                  end else begin
                     state_q   <= AP_CHASE_Y;
                     keycode_q <= key_y;
                  end
               end
            end

            AP_CHASE_X: begin
               axis_cnt_q <= axis_cnt_q + 8'd1;
               if (dz_x) begin
                  axis_cnt_q <= 8'd0;
                  if (dz_y) begin
                     state_q   <= AP_ARRIVED;
                     keycode_q <= KEY_NONE;
                     busy_q    <= 1'b0;
                     arrived_q <= 1'b1;
                  end else begin
                     state_q   <= AP_CHASE_Y;
                     keycode_q <= key_y;
                  end
               end else if (axis_cnt_q == HOLD_LAST && !dz_y) begin
                  // Hold budget spent on X while Y still needs work: staircase over
                  axis_cnt_q <= 8'd0;
                  state_q    <= AP_CHASE_Y;
                  keycode_q  <= key_y;
               end else begin
                  keycode_q <= key_x;
               end
            end

            AP_CHASE_Y: begin
               axis_cnt_q <= axis_cnt_q + 8'd1;
               if (dz_y) begin
                  axis_cnt_q <= 8'd0;
                  if (dz_x) begin
                     state_q   <= AP_ARRIVED;
                     keycode_q <= KEY_NONE;
                     busy_q    <= 1'b0;
                     arrived_q <= 1'b1;
                  end else begin
                     state_q   <= AP_CHASE_X;
                     keycode_q <= key_x;
                  end
               end else if (axis_cnt_q == HOLD_LAST && !dz_x) begin
                  axis_cnt_q <= 8'd0;
                  state_q    <= AP_CHASE_X;
                  keycode_q  <= key_x;
               end else begin
                  keycode_q <= key_y;
               end
            end

            AP_ARRIVED: begin
               keycode_q <= KEY_NONE;
               // Target moved or ball was knocked out of the zone: react again
               if (!dz_x || !dz_y) begin
                  state_q     <= AP_REACT;
                  react_cnt_q <= 8'd0;
                  busy_q      <= 1'b1;
                  arrived_q   <= 1'b0;
               end
            end

            default: begin
               state_q     <= AP_IDLE;
               react_cnt_q <= 8'd0;
               axis_cnt_q  <= 8'd0;
               keycode_q   <= KEY_NONE;
               busy_q      <= 1'b0;
               arrived_q   <= 1'b0;
            end
         endcase
      end
   end

   assign keycode = keycode_q;
   assign busy    = busy_q;
   assign arrived = arrived_q;

endmodule

// File: tb/tb_ball_autopilot.sv
// Directed bench for ball_autopilot with a closed-loop ball mover model.
// Mover: keycode registered into a motion register, position moves 1 px/frame, clamped at walls.
// Own position comes from the model when mover_on, else straight from set_x/set_y.
module tb_ball_autopilot;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       enable;
   logic [7:0] manual_keycode;
   logic [9:0] target_x, target_y;
   logic [9:0] set_x, set_y;
   logic [9:0] mov_x, mov_y;
   logic [9:0] own_x, own_y;
   logic [7:0] keycode;
   logic       busy, arrived;
   logic       mover_on;
   int         mx, my;
   int         total = 0;
   int         bad   = 0;

   always #5 frame_clk = ~frame_clk;

   ball_autopilot #(.DEAD_ZONE(2), .REACT_FRAMES(8), .AXIS_HOLD(16)) dut (
      .frame_clk      (frame_clk),
      .Reset          (Reset),
      .enable         (enable),
      .manual_keycode (manual_keycode),
      .own_x          (own_x),
      .own_y          (own_y),
      .target_x       (target_x),
      .target_y       (target_y),
      .keycode        (keycode),
      .busy           (busy),
      .arrived        (arrived)
   );

   assign own_x = mover_on ? mov_x : set_x;
   assign own_y = mover_on ? mov_y : set_y;

   function automatic logic [9:0] clamp(input int v, input int hi);
      if (v < 0)  return 10'd0;
      if (v > hi) return 10'(hi);
      return 10'(v);
   endfunction

   // Ball mover model: two-stage registered motion, walls at 639 / 479
   always @(posedge frame_clk) begin
      if (!mover_on) begin
         mov_x <= set_x;
         mov_y <= set_y;
         mx    <= 0;
         my    <= 0;
      end else begin
         mov_x <= clamp(int'(mov_x) + mx, 639);
         mov_y <= clamp(int'(mov_y) + my, 479);
         case (keycode)
            8'd79:   begin mx <= 1;  my <= 0;  end
            8'd80:   begin mx <= -1; my <= 0;  end
            8'd81:   begin mx <= 0;  my <= 1;  end
            8'd82:   begin mx <= 0;  my <= -1; end
            default: begin mx <= 0;  my <= 0;  end
         endcase
      end
   end

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input logic [31:0] obs,
                            input logic [31:0] lo, input logic [31:0] hi);
      total++;
      assert (((obs >= lo) && (obs <= hi)) === 1'b1)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_arrived(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if (arrived === 1'b1) ok = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int n, r, viol;

      Reset          = 1'b1;
      enable         = 1'b0;
      manual_keycode = 8'd0;
      target_x       = 10'd0;
      target_y       = 10'd0;
      set_x          = 10'd0;
      set_y          = 10'd0;
      mover_on       = 1'b0;

      // Reset values
      #12;
      chk("rst_key", 32'(keycode), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_arr", 32'(arrived), 32'd0);
      Reset = 1'b0;

      // Manual pass-through, one frame of latency
      manual_keycode = 8'd80;
      step();
      chk("pass_80", 32'(keycode), 32'd80);
      chk("pass_busy", 32'(busy), 32'd0);
      manual_keycode = 8'd0;
      step();
      chk("pass_0", 32'(keycode), 32'd0);
      manual_keycode = 8'd82;
      chk("pass_hold", 32'(keycode), 32'd0);
      step();
      chk("pass_82", 32'(keycode), 32'd82);

      // Reaction delay then LEFT toward (470,240)
      manual_keycode = 8'd0;
      set_x = 10'd480; set_y = 10'd240;
      target_x = 10'd470; target_y = 10'd240;
      step();
      mover_on = 1'b1;
      enable   = 1'b1;
      step();
      chk("react_busy", 32'(busy), 32'd1);
      chk("react_key0", 32'(keycode), 32'd0);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("react_key", 32'(keycode), 32'd0);
      end
      step();
      chk("first_left", 32'(keycode), 32'd80);
      chk("chase_busy", 32'(busy), 32'd1);
      wait_arrived(60, ok);
      chk("arrive1", 32'(ok), 32'd1);
      chk_range("arr1_x", 32'(own_x), 32'd468, 32'd472);
      chk("arr1_key", 32'(keycode), 32'd0);
      chk("arr1_busy", 32'(busy), 32'd0);
      repeat (3) step();
      chk_range("arr1_settle_x", 32'(own_x), 32'd468, 32'd472);
      chk("arr1_stay", 32'(arrived), 32'd1);

      // Staircase (100,100) -> (140,120)
      enable   = 1'b0;
      mover_on = 1'b0;
      set_x = 10'd100; set_y = 10'd100;
      target_x = 10'd140; target_y = 10'd120;
      step();
      mover_on = 1'b1;
      enable   = 1'b1;
      n = 0;
      while (keycode === 8'd0 && n < 20) begin step(); n++; end
      chk("stair_delay", 32'(n), 32'd9);
      r = 0;
      while (keycode === 8'd79 && r < 40) begin step(); r++; end
      chk("run_right", 32'(r), 32'd16);
      chk("then_down", 32'(keycode), 32'd81);
      r = 0;
      while (keycode === 8'd81 && r < 40) begin step(); r++; end
      chk("run_down", 32'(r), 32'd16);
      chk("back_right", 32'(keycode), 32'd79);
      wait_arrived(200, ok);
      chk("arrive2", 32'(ok), 32'd1);
      repeat (3) step();
      chk_range("arr2_x", 32'(own_x), 32'd138, 32'd142);
      chk_range("arr2_y", 32'(own_y), 32'd118, 32'd122);
      chk("arr2_arr", 32'(arrived), 32'd1);
      chk("arr2_busy", 32'(busy), 32'd0);

      // Target jumps +50 in Y from ARRIVED
      target_y = 10'd170;
      step();
      chk("rejump_busy", 32'(busy), 32'd1);
      chk("rejump_arr", 32'(arrived), 32'd0);
      chk("rejump_key", 32'(keycode), 32'd0);
      repeat (7) step();
      chk("rejump_react", 32'(keycode), 32'd0);
      step();
      chk("rejump_down", 32'(keycode), 32'd81);
      wait_arrived(120, ok);
      chk("arrive3", 32'(ok), 32'd1);
      repeat (3) step();
      chk_range("arr3_y", 32'(own_y), 32'd168, 32'd172);

      // Unreachable target beyond the right wall
      target_x = 10'd700;
      repeat (9) step();
      chk("wall_key", 32'(keycode), 32'd79);
      viol = 0;
      for (int i = 0; i < 600; i++) begin
         step();
         if (keycode !== 8'd79 || busy !== 1'b1 || arrived !== 1'b0) viol++;
      end
      chk("wall_hold", 32'(viol), 32'd0);
      chk("wall_x", 32'(own_x), 32'd639);
      manual_keycode = 8'd7;
      enable = 1'b0;
      step();
      chk("drop_key", 32'(keycode), 32'd7);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_arr", 32'(arrived), 32'd0);

      // Asynchronous reset in the middle of CHASE_X
      manual_keycode = 8'd0;
      enable = 1'b1;
      repeat (9) step();
      chk("mid_key", 32'(keycode), 32'd79);
      chk("mid_busy", 32'(busy), 32'd1);
      #2 Reset = 1'b1;
      #1;
      chk("arst_key", 32'(keycode), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_arr", 32'(arrived), 32'd0);
      #2;
      Reset          = 1'b0;
      enable         = 1'b0;
      mover_on       = 1'b0;
      manual_keycode = 8'd4;
      step();
      chk("post_rst_key", 32'(keycode), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
